// File: rtl/wb_ctrl.sv
// wb_ctrl: register-file writeback arbiter with in-order load queue, ALU skid buffer and pending-load scoreboard.
// Optional feature: define WB_BYPASS_EN to add byp_valid/byp_addr/byp_data forwarding outputs.
module wb_ctrl #(
  parameter int LDQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_issue,
  input  logic [4:0]  ld_rd,
  output logic        ld_ready,
  input  logic        mem_valid,
  input  logic [31:0] mem_data,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic [31:0] busy,
`ifdef WB_BYPASS_EN
  output logic        byp_valid,
  output logic [4:0]  byp_addr,
  output logic [31:0] byp_data,
`endif
  output logic        err
);
  localparam int PW = $clog2(LDQ_DEPTH);
  localparam int CW = PW + 1;
  logic [4:0]    q [LDQ_DEPTH];
  logic [PW-1:0] head, tail, off;
  logic [CW-1:0] count;
  logic          skid_full;
  logic [4:0]    skid_rd;
  logic [31:0]   skid_data;
  logic          push, pop, alu_fire, we;
  logic [4:0]    wa;
  logic [31:0]   wd;

  assign alu_ready = ~skid_full;
  assign ld_ready  = count < CW'(LDQ_DEPTH);
  assign push      = ld_issue & ld_ready;
  assign pop       = mem_valid & (count != '0);
  assign alu_fire  = alu_valid & alu_ready;

`ifdef WB_BYPASS_EN
  assign byp_valid = wr_en;
  assign byp_addr  = wr_addr;
  assign byp_data  = wr_data;
`endif

  // Writeback source select: load response first, then a held ALU result, then a fresh ALU result.
  always_comb begin
    we = pop | skid_full | alu_fire;
    wa = pop ? q[head] : skid_full ? skid_rd : alu_rd;
    wd = pop ? mem_data : skid_full ? skid_data : alu_data;
  end

  // Scoreboard: a register is busy while any live queue slot targets it (r0 never).
  always_comb begin
    busy = '0;
    off  = '0;
    for (int j = 0; j < LDQ_DEPTH; j++) begin
      off = PW'(j) - head;
      if (CW'(off) < count && q[j] != 5'd0) busy[q[j]] = 1'b1;
    end
  end

  // Load destination storage; slots outside the live window are ignored, so no reset needed.
  always_ff @(posedge clk)
    if (push) q[tail] <= ld_rd;

  // Queue pointers, skid buffer, sticky error and the registered write port.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      err       <= 1'b0;
      skid_full <= 1'b0;
      skid_rd   <= '0;
      skid_data <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      head      <= head + PW'(pop);
      tail      <= tail + PW'(push);
      count     <= count + CW'(push) - CW'(pop);
      err       <= err | (mem_valid & (count == '0));
      skid_full <= pop & (skid_full | alu_fire);
      if (pop & alu_fire) begin
        skid_rd   <= alu_rd;
        skid_data <= alu_data;
      end
      wr_en   <= we & (wa != 5'd0);
      wr_addr <= wa;
      wr_data <= wd;
    end
endmodule

// File: tb/tb_wb_ctrl.sv
// tb_wb_ctrl: directed and randomized checks of wb_ctrl against a queue-based reference model.
module tb_wb_ctrl;
  localparam int D = 4;
  logic        clk = 1'b0, rst = 1'b1;
  logic        alu_valid = 1'b0, ld_issue = 1'b0, mem_valid = 1'b0;
  logic [4:0]  alu_rd = '0, ld_rd = '0;
  logic [31:0] alu_data = '0, mem_data = '0;
  logic        alu_ready, ld_ready, wr_en, err;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data, busy;
  int          checks = 0, failures = 0;
  logic [4:0]  lq [$];
  logic [36:0] sk [$];
  bit          m_wen = 0, m_err = 0;
  logic [4:0]  m_wa = '0;
  logic [31:0] m_wd = '0;

  always #5 clk = ~clk;

  wb_ctrl #(.LDQ_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_rd(ld_rd), .ld_ready(ld_ready),
    .mem_valid(mem_valid), .mem_data(mem_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .err(err)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_busy();
    logic [31:0] b;
    b = '0;
    foreach (lq[i]) if (lq[i] != 5'd0) b[lq[i]] = 1'b1;
    return b;
  endfunction

  task automatic step();
    bit          full, mem_ok, alu_ok, w;
    logic [4:0]  a;
    logic [31:0] d;
    full   = lq.size() >= D;
    mem_ok = mem_valid && lq.size() != 0;
    alu_ok = alu_valid && sk.size() == 0;
    w = 0; a = '0; d = '0;
    if (mem_ok) begin
      a = lq.pop_front(); d = mem_data; w = 1;
      if (alu_ok) sk.push_back({alu_rd, alu_data});
    end else if (sk.size() != 0) begin
      {a, d} = sk.pop_front(); w = 1;
    end else if (alu_ok) begin
      a = alu_rd; d = alu_data; w = 1;
    end
    if (mem_valid && !mem_ok) m_err = 1;
    if (ld_issue && !full) lq.push_back(ld_rd);
    m_wen = w && a != 5'd0; m_wa = a; m_wd = d;
  endtask

  task automatic cmp();
    check("wr_en", wr_en, m_wen);
    if (m_wen) begin
      check("wr_addr", wr_addr, m_wa);
      check("wr_data", wr_data, m_wd);
    end
    check("busy", busy, m_busy());
    check("err", err, m_err);
    check("alu_ready", alu_ready, sk.size() == 0);
    check("ld_ready", ld_ready, lq.size() < D);
  endtask

  task automatic cyc(bit av, logic [4:0] ar, logic [31:0] ad, bit li, logic [4:0] lr, bit mv, logic [31:0] md);
    alu_valid = av; alu_rd = ar; alu_data = ad;
    ld_issue = li; ld_rd = lr; mem_valid = mv; mem_data = md;
    step();
    @(posedge clk);
    @(negedge clk);
    cmp();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    alu_valid = 0; ld_issue = 0; mem_valid = 0;
    #2 rst = 1'b1;
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_alu_ready", alu_ready, 1);
    check("rst_ld_ready", ld_ready, 1);
    lq.delete(); sk.delete(); m_err = 0; m_wen = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    // single ALU result appears for exactly one cycle
    cyc(1, 5, 32'h1234, 0, 0, 0, 0);
    idle();
    // mem/ALU collision: load wins, ALU result drains one cycle later
    cyc(0, 0, 0, 1, 7, 0, 0);
    check("busy7_set", busy[7], 1);
    cyc(1, 3, 32'h55, 0, 0, 1, 32'hAAAA0000);
    check("busy7_clr", busy[7], 0);
    idle();
    idle();
    // fill the queue, drop the fifth issue, drain in order
    for (int i = 1; i <= 4; i++) cyc(0, 0, 0, 1, 5'(i), 0, 0);
    cyc(0, 0, 0, 1, 9, 0, 0);
    check("busy9_dropped", busy[9], 0);
    for (int i = 1; i <= 4; i++) cyc(0, 0, 0, 0, 0, 1, 32'hD000 + i);
    // duplicate destinations keep the register busy until the last response
    cyc(0, 0, 0, 1, 6, 0, 0);
    cyc(0, 0, 0, 1, 6, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h61);
    check("busy6_held", busy[6], 1);
    cyc(0, 0, 0, 0, 0, 1, 32'h62);
    check("busy6_clear", busy[6], 0);
    // full queue with simultaneous pop: issue still refused
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 5'(20 + i), 0, 0);
    cyc(0, 0, 0, 1, 30, 1, 32'hF0);
    check("busy30_refused", busy[30], 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 32'hF1 + i);
    // response to empty queue and write to r0
    cyc(0, 0, 0, 0, 0, 1, 32'hBAD);
    cyc(1, 0, 32'h77, 0, 0, 0, 0);
    idle();
    // reset mid-operation with two loads pending and skid full
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 5'(10 + i), 0, 0);
    cyc(1, 8, 32'h88, 0, 0, 1, 32'h10);
    do_reset();
    idle();
    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      bit mv;
      mv = $urandom_range(0, 2) == 0;
      if (lq.size() == 0 && sk.size() != 0) mv = 0;
      if (n % 200 == 199) do_reset();
      else cyc($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
               $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), mv, $urandom);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_ctrl.md
WB_CTRL -- requirements
Module: wb_ctrl

Interface
REQ-001 SHALL have parameter LDQ_DEPTH, default 4, meaning the number of outstanding loads tracked (power of two, 2..8).
REQ-002 SHALL have port clk, input, 1, the clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset: asynchronous, active-high.
REQ-004 SHALL have port alu_valid, input, 1, meaning an ALU result is offered.
REQ-005 SHALL have port alu_ready, output, 1, meaning an offered ALU result is accepted; a transfer occurs when alu_valid and alu_ready are both 1.
REQ-006 SHALL have ports alu_rd, input, 5, and alu_data, input, 32, meaning the ALU destination and value.
REQ-007 SHALL have port ld_issue, input, 1, meaning a load has been issued and its destination is reserved.
REQ-008 SHALL have port ld_rd, input, 5, meaning the load destination.
REQ-009 SHALL have port ld_ready, output, 1, meaning the load queue is not full.
REQ-010 SHALL have ports mem_valid, input, 1, and mem_data, input, 32, meaning an in-order load response.
REQ-011 SHALL have ports wr_en, output, 1; wr_addr, output, 5; and wr_data, output, 32, forming the register-file write port.
REQ-012 SHALL have port busy, output, 32, the per-register pending-load scoreboard.
REQ-013 SHALL have port err, output, 1, a sticky flag for a protocol error.

Function
REQ-014 SHALL register wr_en/wr_addr/wr_data: a result accepted at edge N is on the write port during cycle N+1 for exactly one cycle.
REQ-015 SHALL give mem_valid priority over ALU: when both arrive in the same cycle, the mem write occurs in N+1 and the ALU result is held in a 1-entry skid register.
REQ-016 SHALL write the skid entry in the first cycle with no mem_valid; a continuous stream of mem_valid may hold the skid entry indefinitely.
REQ-017 SHALL drive alu_ready = ~skid_full combinationally from registered state.
REQ-018 SHALL push ld_rd into the load FIFO on ld_issue & ld_ready.
REQ-019 SHALL drop ld_issue while the queue is full: no push, no busy change.
REQ-020 SHALL pop the FIFO head on mem_valid and use the popped head as wr_addr.
REQ-021 SHALL drive ld_ready = (count < LDQ_DEPTH) from the count before the edge; a same-cycle pop does not admit an issue when full.
REQ-022 SHALL support a simultaneous push and pop, with count unchanged and pointers wrapping modulo LDQ_DEPTH.
REQ-023 SHALL ignore mem_valid while the queue is empty and set err, cleared only by reset.
REQ-024 SHALL suppress writes to register 0, with wr_en remaining 0; this also consumes the FIFO entry or ALU transfer.
REQ-025 SHALL never set busy[0].
REQ-026 SHALL set busy[r] at the edge accepting ld_issue for r, so it is visible from N+1.
REQ-027 SHALL clear busy[r] at the edge popping a load for r, unless another queued entry (excluding the popped head) targets r or a same-edge push targets r; set wins.
REQ-028 SHALL take no action on ALU results in relation to busy.

Reset
REQ-029 SHALL, while rst=1, force wr_en=0, wr_addr=0, wr_data=0, busy=0, err=0, skid empty, FIFO count/pointers=0, alu_ready=1, and ld_ready=1.
REQ-030 SHALL discard in-flight loads and any held ALU result on reset mid-operation.

Configuration
REQ-031 SHALL, with WB_BYPASS_EN defined, add outputs byp_valid (1), byp_addr (5), and byp_data (32), equal to wr_en/wr_addr/wr_data, for same-cycle operand forwarding to readers.
REQ-032 SHALL, with WB_BYPASS_EN undefined, omit these ports, with all other behaviour identical.

Verification
REQ-033 SHALL cover: alu_valid, rd=5, data=0x1234 at edge 1 -> wr_en=1, wr_addr=5, wr_data=0x1234 in cycle 2 only.
REQ-034 SHALL cover: ld_issue rd=7; later mem_valid 0xAAAA0000 and alu_valid rd=3, 0x55 in the same cycle -> write r7=0xAAAA0000, then r3=0x55 next cycle; alu_ready=0 for one cycle; busy[7] 1->0 with the first write.
REQ-035 SHALL cover: four ld_issue to rd 1,2,3,4 -> ld_ready=0; fifth issue rd=9 ignored with busy[9]=0; four responses write r1..r4 in order and ld_ready returns to 1.
REQ-036 SHALL cover: two loads both to rd=6, one response -> busy[6] stays 1; second response -> busy[6]=0.
REQ-037 SHALL cover: mem_valid with an empty queue -> no write, err=1 until rst; ALU to rd=0 -> wr_en stays 0.
REQ-038 SHALL cover: rst asserted mid-cycle with two loads pending and skid full -> outputs zero immediately; after release, ld_ready=1 and alu_ready=1.
